// File: rtl/combinatorics_pkg.sv
// combinatorics_pkg: operation and FSM state encodings for combinatorics_seq
package combinatorics_pkg;
  typedef enum logic [1:0] {OP_FACT, OP_NPR, OP_NCR, OP_RSVD} op_t;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ITER, S_DONE} state_t;
endpackage

// File: rtl/comb_step_dp.sv
// comb_step_dp: one multiply / exact-divide / overflow-compare step
module comb_step_dp #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 8
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [N_WIDTH-1:0] factor,
  input  logic [N_WIDTH-1:0] divisor,
  output logic [WIDTH-1:0]   value,
  output logic               ovf
);
  logic [WIDTH+N_WIDTH-1:0] prod;
  logic [WIDTH+N_WIDTH-1:0] quot;
  logic [N_WIDTH-1:0]       dv;
  always_comb begin
    dv    = (divisor == '0) ? N_WIDTH'(1) : divisor;
    prod  = {{N_WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, factor};
    quot  = prod / {{WIDTH{1'b0}}, dv};
    ovf   = |quot[WIDTH+N_WIDTH-1:WIDTH];
    value = ovf ? '1 : quot[WIDTH-1:0];
  end
endmodule

// File: rtl/combinatorics_seq.sv
// combinatorics_seq: sequential factorial / nPr / nCr engine, one step per cycle
module combinatorics_seq
  import combinatorics_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [N_WIDTH-1:0] n,
  input  logic [N_WIDTH-1:0] r,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic               ovf
);
  state_t             state, state_n;
  op_t                op_q;
  logic [N_WIDTH-1:0] n_q, r_q, k_q, j;
  logic [N_WIDTH-1:0] nmr, iters, factor, divisor;
  logic [WIDTH-1:0]   acc, value;
  logic               invalid, step_ovf, last;

  comb_step_dp #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) u_dp (
    .acc(acc), .factor(factor), .divisor(divisor), .value(value), .ovf(step_ovf)
  );

  // nPr and nCr share the factor sequence n-k+1..n; only nCr divides by j
  always_comb begin
    nmr     = n_q - r_q;
    invalid = (op_q == OP_RSVD) || (op_q != OP_FACT && r_q > n_q);
    iters   = op_q == OP_FACT ? (n_q > N_WIDTH'(1) ? n_q - N_WIDTH'(1) : '0) :
              op_q == OP_NPR  ? r_q : (r_q < nmr ? r_q : nmr);
    factor  = op_q == OP_FACT ? j + N_WIDTH'(1) : n_q - k_q + j;
    divisor = op_q == OP_NCR ? j : N_WIDTH'(1);
    last    = j == k_q;
    state_n = state == S_IDLE  ? (start ? S_CHECK : S_IDLE) :
              state == S_CHECK ? ((invalid || iters == '0) ? S_DONE : S_ITER) :
              state == S_ITER  ? ((step_ovf || last) ? S_DONE : S_ITER) : S_IDLE;
    busy    = state != S_IDLE;
    done    = state == S_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_FACT;
      n_q    <= '0;
      r_q    <= '0;
      k_q    <= '0;
      j      <= '0;
      acc    <= '0;
      result <= '0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        op_q   <= op_t'(op);
        n_q    <= n;
        r_q    <= r;
        result <= '0;
        err    <= 1'b0;
        ovf    <= 1'b0;
      end
      if (state == S_CHECK) begin
        acc <= WIDTH'(1);
        j   <= N_WIDTH'(1);
        k_q <= invalid ? '0 : iters;
        if (state_n == S_DONE) begin
          err    <= invalid;
          result <= invalid ? '0 : WIDTH'(1);
        end
      end
      if (state == S_ITER) begin
        acc <= value;
        j   <= j + N_WIDTH'(1);
        if (state_n == S_DONE) begin
          result <= value;
          ovf    <= step_ovf;
        end
      end
    end
  end
endmodule

// File: doc/combinatorics_seq.md
COMBINATORICS_SEQ -- requirements
Module: combinatorics_seq

Interface
REQ-001 Parameter WIDTH, default 32: result width in bits.
REQ-002 Parameter N_WIDTH, default 8: width of unsigned operands n, r.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request; accepted only when busy=0.
REQ-006 op  in  2  operation select: 00 factorial(n), 01 nPr, 10 nCr, 11 reserved.
REQ-007 n, r  in  N_WIDTH each  unsigned operands, sampled on the accepting edge.
REQ-008 busy  out  1  high while an operation is in progress.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 result  out  WIDTH  registered result, held until the next accepted start.
REQ-011 err  out  1  invalid request (op=11, or r>n for nPr/nCr), valid with done.
REQ-012 ovf  out  1  result exceeded WIDTH bits, valid with done.

Function
REQ-013 FSM states: IDLE, CHECK, ITER, DONE; IDLE->CHECK on start&&!busy, with n, r, op captured.
REQ-014 CHECK: validate the request, initialise acc=1, load the iteration counter, and select the next state: DONE if the request is invalid or ITERS=0, else ITER.
REQ-015 Iteration counts: factorial ITERS=max(n-1,0), factors 2..n; nPr ITERS=r, factors n-r+1..n; nCr ITERS=k=min(r,n-r), step j=1..k: acc=(acc*(n-k+j))/j.
REQ-016 Each ITER cycle performs exactly one step; the intermediate product is WIDTH+N_WIDTH bits wide; the nCr division is exact and combinational.
REQ-017 Overflow: if the post-step value is >=2^WIDTH, set ovf=1, set result to all-ones, and go to DONE at that edge, skipping the remaining steps.
REQ-018 done is high for exactly the one cycle following accepting edge +1+ITERS_executed; DONE->IDLE unconditionally.
REQ-019 busy is high in CHECK, ITER and DONE, and low only in IDLE; start is ignored while busy=1, with no queuing.
REQ-020 Invalid request: err=1, result=0, ovf=0, ITERS=0.
REQ-021 Boundaries: 0!=1!=1; nPr(n,0)=1; nCr(n,0)=nCr(n,n)=1; nPr(0,0)=nCr(0,0)=1.
REQ-022 err, ovf and result update only on entry to DONE; they are cleared to 0 on an accepted start.
REQ-023 No combinational path from inputs to outputs; all outputs are registered.

Reset
REQ-024 rst=1 forces state IDLE and busy=done=err=ovf=0, result=0 on the next edge, from any state, including mid-ITER.
REQ-025 start asserted in the same cycle as rst is ignored; the first accept is possible on the first edge with rst=0.

Structure
REQ-026 Package combinatorics_pkg SHALL hold the op_t enum (OP_FACT, OP_NPR, OP_NCR, OP_RSVD) and the state_t enum.
REQ-027 The single sub-module comb_step_dp SHALL contain the combinational multiply / optional-divide / overflow-compare datapath, parametrised by WIDTH and N_WIDTH; the FSM, counter and registers stay in combinatorics_seq.

Verification (WIDTH=32, N_WIDTH=8)
REQ-028 op=00, n=5 -> result=120, err=0, ovf=0; done 5 edges after accept; busy high throughout.
REQ-029 op=00, n=12 -> 479001600, no ovf; n=13 -> ovf=1, result=32'hFFFFFFFF, done 13 edges after accept.
REQ-030 op=10, n=52, r=5 -> 2598960 after 6 edges; op=10, n=10, r=7 -> 120 after 4 edges (k=3).
REQ-031 op=01, n=5, r=6 -> err=1, result=0, done 1 edge after accept; op=11 -> err=1; op=01, n=7, r=0 -> 1.
REQ-032 start pulsed during ITER with different operands -> ignored; the original result completes unchanged.
REQ-033 rst asserted mid-ITER of 10! -> next edge: IDLE, all outputs 0; a following 4! returns 24 normally.
